// File: rtl/riscv_pkg.sv
// Shared load/store encodings, LSU state and fault codes, and request legality check.
// Latency: n/a (package). Backpressure: n/a.
// Consumers: decoder (LDST_*), riscv_lsu and lsu_align.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_RESP
    } lsu_state_t;

    localparam logic [1:0] LSU_FAULT_NONE     = 2'b00;
    localparam logic [1:0] LSU_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] LSU_FAULT_BADSIZE  = 2'b11;

    // Context the response path needs to extract load data.
    typedef struct packed {
        logic [2:0] size;
        logic [1:0] addr_lo;
    } lsu_ctx_t;

    // Bad size outranks misalignment; unsigned sizes only make sense for loads.
    function automatic logic [1:0] lsu_check(input logic we, input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic [1:0] code;
        code = LSU_FAULT_NONE;
        case (size)
            LDST_B:          code = LSU_FAULT_NONE;
            LDST_H:          code = addr_lo[0] ? LSU_FAULT_MISALIGN : LSU_FAULT_NONE;
            LDST_W:          code = (addr_lo != 2'b00) ? LSU_FAULT_MISALIGN : LSU_FAULT_NONE;
            LDST_BU:         code = we ? LSU_FAULT_BADSIZE : LSU_FAULT_NONE;
            LDST_HU:         code = we ? LSU_FAULT_BADSIZE
                                   : (addr_lo[0] ? LSU_FAULT_MISALIGN : LSU_FAULT_NONE);
            default:         code = LSU_FAULT_BADSIZE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane helper: byte enables, store replication, load extract with sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd_ext
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        byte_sh = rd_word >> {addr_lo, 3'b000};
        half_sh = rd_word >> {addr_lo[1], 4'b0000};
        be      = 4'b0000;
        wd_rep  = 32'h0;
        rd_ext  = 32'h0;
        case (size)
            LDST_B, LDST_BU: begin
                be     = 4'b0001 << addr_lo;
                wd_rep = {4{wd[7:0]}};
                rd_ext = (size == LDST_B) ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                          : {24'h0, byte_sh[7:0]};
            end
            LDST_H, LDST_HU: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wd[15:0]}};
                rd_ext = (size == LDST_H) ? {{16{half_sh[15]}}, half_sh[15:0]}
                                          : {16'h0, half_sh[15:0]};
            end
            LDST_W: begin
                be     = 4'b1111;
                wd_rep = wd;
                rd_ext = rd_word;
            end
            default: begin
                be     = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between core datapath and data memory; checks, aligns and extends accesses.
// Latency: mem_req_o one cycle after core_req_i; response one cycle after mem_ready_i (min stall 2).
// Backpressure: core stalled until RESP; mem_req_o held until mem_ready_i or timeout.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t  state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]  fault_r;
    logic [31:0] rd_r;
    lsu_ctx_t    ctx_r;
    logic [1:0]  check_code;
    logic        timeout_hit;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic [31:0] resp_rd;
    logic [31:0] req_rd_unused;
    logic [3:0]  resp_be_unused;
    logic [31:0] resp_wd_unused;

    lsu_align u_req_align (
        .size    (core_size_i),
        .addr_lo (core_addr_i[1:0]),
        .wd      (core_wd_i),
        .rd_word (mem_rd_i),
        .be      (req_be),
        .wd_rep  (req_wd),
        .rd_ext  (req_rd_unused)
    );

    lsu_align u_resp_align (
        .size    (ctx_r.size),
        .addr_lo (ctx_r.addr_lo),
        .wd      (mem_wd_o),
        .rd_word (mem_rd_i),
        .be      (resp_be_unused),
        .wd_rep  (resp_wd_unused),
        .rd_ext  (resp_rd)
    );

    assign check_code  = lsu_check(core_we_i, core_size_i, core_addr_i[1:0]);
    // Fires on the last permitted BUSY cycle; mem_ready_i in that cycle still wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (core_req_i) state_nxt = (check_code != LSU_FAULT_NONE) ? LSU_RESP : LSU_BUSY;
            LSU_BUSY: if (mem_ready_i || timeout_hit) state_nxt = LSU_RESP;
            LSU_RESP: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= LSU_IDLE;
            cnt        <= '0;
            fault_r    <= LSU_FAULT_NONE;
            rd_r       <= 32'h0;
            ctx_r      <= '0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0000;
            mem_addr_o <= 32'h0;
            mem_wd_o   <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                LSU_IDLE: begin
                    cnt <= '0;
                    if (core_req_i) begin
                        fault_r <= check_code;
                        rd_r    <= 32'h0;
                        if (check_code == LSU_FAULT_NONE) begin
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= req_be;
                            mem_addr_o <= {core_addr_i[31:2], 2'b00};
                            mem_wd_o   <= req_wd;
                            ctx_r      <= '{size: core_size_i, addr_lo: core_addr_i[1:0]};
                        end
                    end
                end
                LSU_BUSY: begin
                    if (mem_ready_i) begin
                        rd_r <= mem_we_o ? 32'h0 : resp_rd;
                    end else if (timeout_hit) begin
                        fault_r <= LSU_FAULT_TIMEOUT;
                        rd_r    <= 32'h0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Reset gates stall so a core still holding req is released immediately.
    assign core_stall_o = core_req_i & (state != LSU_RESP) & ~rst_i;
    assign mem_req_o    = (state == LSU_BUSY);
    assign fault_o      = (state == LSU_RESP) && (fault_r != LSU_FAULT_NONE);
    assign fault_code_o = (state == LSU_RESP) ? fault_r : LSU_FAULT_NONE;
    assign core_rd_o    = rd_r;

endmodule
